// File: rtl/divider_iter.sv
// divider_iter: iterative shift-subtract divider with valid/ready handshakes
// on both the operand and the result side. One quotient bit per cycle.
// Optional feature: define DIVIDER_SIGNED_EN for two's-complement operands
// (adds a one-cycle FIX state that restores the result signs).
module divider_iter #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_dbz
);

`ifdef DIVIDER_SIGNED_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t            state, state_nxt;
    logic              accept;
    logic              div_zero;
    logic [WIDTH-1:0]  rem, quo, div_r;
    logic [CNT_W-1:0]  cnt;
    logic              dbz;
    logic [WIDTH-1:0]  dvd_mag, dvs_mag;
    logic [WIDTH:0]    trial, diff;

    assign div_zero = (i_divisor == '0);

`ifdef DIVIDER_SIGNED_EN
    logic neg_q, neg_r;
    // The core divides magnitudes; signs are reapplied in FIX.
    assign dvd_mag = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
    assign dvs_mag = i_divisor[WIDTH-1]  ? -i_divisor  : i_divisor;
`else
    assign dvd_mag = i_dividend;
    assign dvs_mag = i_divisor;
`endif

    // One extra bit on the trial subtract keeps the shifted-out MSB of rem;
    // diff[WIDTH] set means the trial went negative.
    assign trial = {rem, quo[WIDTH-1]};
    assign diff  = trial - {1'b0, div_r};

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs; DONE with i_ready behaves like IDLE
    // so a waiting operand is taken on the same edge the result leaves.
    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    accept    = 1'b1;
                    state_nxt = div_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_W'(1)) begin
`ifdef DIVIDER_SIGNED_EN
                    state_nxt = FIX;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef DIVIDER_SIGNED_EN
            FIX: state_nxt = DONE;
`endif
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    o_ready = 1'b1;
                    if (i_valid) begin
                        accept    = 1'b1;
                        state_nxt = div_zero ? DONE : RUN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand load, one shift-subtract step per RUN cycle, sign fix.
    // Registers only move on load/RUN/FIX, so results hold while DONE stalls.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rem   <= '0;
            quo   <= '0;
            div_r <= '0;
            cnt   <= '0;
            dbz   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_q <= 1'b0;
            neg_r <= 1'b0;
`endif
        end else if (accept) begin
            if (div_zero) begin
                // Zero divisor bypasses the iteration; raw dividend is returned.
                quo <= '1;
                rem <= i_dividend;
                dbz <= 1'b1;
            end else begin
                rem   <= '0;
                quo   <= dvd_mag;
                div_r <= dvs_mag;
                cnt   <= CNT_W'(WIDTH);
                dbz   <= 1'b0;
            end
`ifdef DIVIDER_SIGNED_EN
            neg_q <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
            neg_r <= i_dividend[WIDTH-1];
`endif
        end else if (state == RUN) begin
            rem <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
            cnt <= cnt - CNT_W'(1);
        end
`ifdef DIVIDER_SIGNED_EN
        else if (state == FIX) begin
            // Truncating division: remainder follows the dividend's sign.
            quo <= neg_q ? -quo : quo;
            rem <= neg_r ? -rem : rem;
        end
`endif
    end

    assign o_quotient  = quo;
    assign o_remainder = rem;
    assign o_dbz       = dbz;

endmodule

// File: tb/tb_divider_iter.sv
// tb_divider_iter: directed bench for divider_iter (WIDTH=32) with a
// scoreboard queue of expected results.
module tb_divider_iter;

`ifdef DIVIDER_SIGNED_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 32;
`endif
    localparam int BUDGET = 200;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_dividend = '0;
    logic [31:0] i_divisor = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;
    logic        o_dbz;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    divider_iter #(.WIDTH(32)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_quotient (o_quotient),
        .o_remainder(o_remainder),
        .o_dbz      (o_dbz)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] q, input logic [31:0] r, input logic dbz);
        exp_t e;
        e.q = q; e.r = r; e.dbz = dbz;
        sb.push_back(e);
    endtask

    // Counts edges until o_valid; an expired budget counts as a failure.
    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!o_valid && n < BUDGET) begin
            tick();
            n++;
        end
        if (!o_valid) chk({tag, "_timeout"}, {63'd0, o_valid}, 64'd1);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        chk({tag, "_sb"}, {63'd0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_q"},   o_quotient,  e.q);
            chk({tag, "_r"},   o_remainder, e.r);
            chk({tag, "_dbz"}, o_dbz,       e.dbz);
        end
    endtask

    // Single operation from IDLE: issue, check latency and result, consume.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r,
                          input logic dbz, input int lat, input string tag);
        int n;
        i_dividend = a;
        i_divisor  = b;
        i_valid    = 1'b1;
        push(q, r, dbz);
        tick();
        i_valid = 1'b0;
        wait_valid(tag, n);
        chk({tag, "_lat"}, n, lat);
        check_out(tag);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    initial begin
        int          n;
        int          bad;
        logic [31:0] q0, r0, a, b;

        // Reset state
        #2;
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_q", o_quotient, 0);
        chk("rst_r", o_remainder, 0);
        chk("rst_dbz", o_dbz, 0);
        #20 i_rst = 1'b1;
        tick();

        // Equal operands, exact latency
        run_op(32'hDEADBEEF, 32'hDEADBEEF, 32'd1, 32'd0, 1'b0, LAT, "eq");

        // 100/7 followed back-to-back by 0xFFFFFFFF/1
        i_dividend = 32'd100; i_divisor = 32'd7; i_valid = 1'b1;
        push(32'd14, 32'd2, 1'b0);
        tick();
        i_dividend = 32'hFFFFFFFF; i_divisor = 32'd1; i_ready = 1'b1;
        wait_valid("b2b1", n);
        chk("b2b1_lat", n, LAT);
        chk("b2b_ready", o_ready, 1);
        check_out("b2b1");
        push(32'hFFFFFFFF, 32'd0, 1'b0);
        tick();
        i_valid = 1'b0;
        wait_valid("b2b2", n);
        chk("b2b2_lat", n, LAT);
        check_out("b2b2");
        tick();
        i_ready = 1'b0;

        // Divide by zero, then a normal op clears the flag
        run_op(32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234, 1'b1, 0, "dbz");
        run_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, LAT, "after_dbz");

        // Back-pressure: result held 10 cycles, new operand ignored
        i_dividend = 32'd50; i_divisor = 32'd8; i_valid = 1'b1;
        push(32'd6, 32'd2, 1'b0);
        tick();
        i_valid = 1'b0;
        wait_valid("bp", n);
        q0 = o_quotient; r0 = o_remainder; bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                i_dividend = 32'd77; i_divisor = 32'd5; i_valid = 1'b1;
            end
            tick();
            if (!o_valid || o_ready || o_quotient !== q0 || o_remainder !== r0) bad++;
        end
        chk("bp_stable", bad, 0);
        i_valid = 1'b0;
        check_out("bp");
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("bp_ignored_valid", o_valid, 0);
        chk("bp_ignored_ready", o_ready, 1);

        // Reset in the middle of RUN
        i_dividend = 32'd1000; i_divisor = 32'd3; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        i_rst = 1'b0;
        #1;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_ready", o_ready, 1);
        chk("mid_rst_q", o_quotient, 0);
        chk("mid_rst_r", o_remainder, 0);
        #2 i_rst = 1'b1;
        tick();
        run_op(32'd10, 32'd3, 32'd3, 32'd1, 1'b0, LAT, "post_rst");

`ifdef DIVIDER_SIGNED_EN
        run_op(32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, LAT, "s_neg7_2");
        run_op(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, LAT, "s_min_m1");
`endif

        // A few random positive operands against a behavioural model
        for (int i = 0; i < 4; i++) begin
            a = $urandom & 32'h7FFFFFFF;
            b = (i % 2 == 1) ? (($urandom & 32'hFF) + 32'd1) : (($urandom & 32'h7FFFFFFF) | 32'd1);
            run_op(a, b, a / b, a % b, 1'b0, LAT, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
